// File: rtl/seq_det_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control,
// saturating match counter and sticky configuration-error flag.
module seq_det_prog #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0010_1010,
    parameter int                 RST_LEN = 6,
    parameter bit                 RST_OVL = 1'b1,
    localparam int                LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LW-1:0]      len_in,
    input  logic               ovl_in,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat;
    logic [LW-1:0]      len;
    logic [LW-1:0]      fill;
    logic               ovl;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_next;
    logic               hit;
    logic               len_ok;

    // Stream qualifier: x is consumed only on edges with en=1 and cfg_load=0;
    // there is no back-pressure, the detector accepts every valid bit.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], x};
        fill_next = (fill >= len) ? len : fill + LW'(1);
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len);
        end
        hit    = en && !cfg_load && (fill_next == len)
                 && (((hist_next ^ pat) & len_mask) == '0);
        len_ok = (len_in != '0) && (len_in <= LW'(MAX_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            pat       <= RST_PAT;
            len       <= LW'(RST_LEN);
            ovl       <= RST_OVL;
            z         <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            z <= hit;

            if (cfg_load) begin
                if (len_ok) begin
                    pat     <= pat_in;
                    len     <= len_in;
                    ovl     <= ovl_in;
                    hist    <= '0;
                    fill    <= '0;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (en) begin
                hist <= hist_next;
                // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
                fill <= (hit && !ovl) ? '0 : fill_next;
            end

            if (cnt_clr) begin
                match_cnt <= hit ? CNT_W'(1) : '0;
            end else if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] pat_in = '0;
    logic [3:0] len_in = '0;
    logic       ovl_in = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       z, z_s;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
    logic       err, err_s;

    int total = 0;
    int bad   = 0;

    seq_det_prog dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
        .z(z), .match_cnt(cnt), .cfg_err(err)
    );

    seq_det_prog #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in), .cnt_clr(cnt_clr),
        .z(z_s), .match_cnt(cnt_s), .cfg_err(err_s)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         mq[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    int         m_cnt_sat;
    bit         m_z;
    bit         m_err;

    task automatic model_reset();
        mq.delete();
        m_pat = 8'h2A; m_len = 6; m_ovl = 1'b1;
        m_cnt = 0; m_cnt_sat = 0; m_z = 1'b0; m_err = 1'b0;
    endtask

    // Matching is judged on the last m_len valid bits received since the
    // last clear point (reset, valid load, or a non-overlapping match).
    task automatic model_edge();
        bit hit;
        hit = 1'b0;
        if (cfg_load) begin
            if (len_in >= 1 && len_in <= 8) begin
                m_pat = pat_in; m_len = int'(len_in); m_ovl = ovl_in;
                mq.delete();
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (en) begin
            mq.push_back(x);
            if (mq.size() > 8) void'(mq.pop_front());
            if (mq.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
            end
            if (hit && !m_ovl) mq.delete();
        end
        m_z = hit;
        if (cnt_clr) begin
            m_cnt     = hit ? 1 : 0;
            m_cnt_sat = hit ? 1 : 0;
        end else if (hit) begin
            m_cnt     = (m_cnt == 255) ? 255 : m_cnt + 1;
            m_cnt_sat = (m_cnt_sat == 3) ? 3 : m_cnt_sat + 1;
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("z", 32'(z), 32'(m_z));
        check("z_sat", 32'(z_s), 32'(m_z));
        check("match_cnt", 32'(cnt), 32'(m_cnt));
        check("match_cnt_sat", 32'(cnt_s), 32'(m_cnt_sat));
        check("cfg_err", 32'(err), 32'(m_err));
        check("cfg_err_sat", 32'(err_s), 32'(m_err));
    endtask

    task automatic step(input logic e, input logic xi, input logic cl, input logic [7:0] pi,
                        input logic [3:0] li, input logic oi, input logic clr);
        en = e; x = xi; cfg_load = cl; pat_in = pi; len_in = li; ovl_in = oi; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic send(input logic xi);
        step(1'b1, xi, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        en = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; x = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rst_z", 32'(z), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       e, xi, cl;
        logic [7:0] pi;
        logic [3:0] li;
        logic       oi, clr;
        logic       ez;
        int         ec;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic e, input logic xi, input logic cl, input logic [7:0] pi,
                     input logic [3:0] li, input logic oi, input logic clr,
                     input logic ez, input int ec, input logic ee);
        vec_t r;
        r.e = e; r.xi = xi; r.cl = cl; r.pi = pi; r.li = li; r.oi = oi; r.clr = clr;
        r.ez = ez; r.ec = ec; r.ee = ee;
        tbl.push_back(r);
    endtask

    // Data-bit row: en=1, no load, no clear.
    task automatic b(input logic xi, input logic ez, input int ec, input logic ee);
        v(1'b1, xi, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, ez, ec, ee);
    endtask

    int pos[$];
    int vcount;
    int npos;

    initial begin
        // Defaults, overlapping 101010 detection.
        b(1,0,0,0); b(0,0,0,0); b(1,0,0,0); b(0,0,0,0); b(1,0,0,0);
        b(0,1,1,0); b(1,0,1,0); b(0,1,2,0); b(1,0,2,0); b(0,1,3,0);
        // Non-overlapping 101010.
        v(1,1,1,8'h2A,4'd6,1'b0,1'b1, 0,0,0);
        b(1,0,0,0); b(0,0,0,0); b(1,0,0,0); b(0,0,0,0); b(1,0,0,0);
        b(0,1,1,0); b(1,0,1,0); b(0,0,1,0); b(1,0,1,0); b(0,0,1,0);
        // Pattern 110, non-overlapping.
        v(1,0,1,8'h06,4'd3,1'b0,1'b1, 0,0,0);
        b(1,0,0,0); b(1,0,0,0); b(0,1,1,0); b(1,0,1,0);
        b(1,0,1,0); b(0,1,2,0); b(1,0,2,0); b(0,0,2,0);
        // Pattern 110, overlapping; high pattern bits set as don't-care.
        v(0,0,1,8'hF6,4'd3,1'b1,1'b1, 0,0,0);
        b(1,0,0,0); b(1,0,0,0); b(0,1,1,0); b(1,0,1,0);
        b(1,0,1,0); b(0,1,2,0); b(1,0,2,0); b(0,0,2,0);
        // Invalid loads keep the old configuration.
        v(1,1,1,8'hFF,4'd0,1'b0,1'b0, 0,2,1);
        b(1,0,2,1); b(1,0,2,1); b(0,1,3,1);
        v(1,1,1,8'h00,4'd9,1'b0,1'b0, 0,3,1);
        v(0,1,0,8'h00,4'd0,1'b0,1'b0, 0,3,1);
        b(1,0,3,1); b(1,0,3,1); b(0,1,4,1);
        // len=1: back-to-back pulses, valid load clears the error flag.
        v(0,0,1,8'h01,4'd1,1'b0,1'b1, 0,0,0);
        b(1,1,1,0); b(1,1,2,0); b(0,0,2,0); b(1,1,3,0);

        do_reset();
        check("reset_model_cnt", 32'(cnt), 32'(m_cnt));
        foreach (tbl[i]) begin
            step(tbl[i].e, tbl[i].xi, tbl[i].cl, tbl[i].pi, tbl[i].li, tbl[i].oi, tbl[i].clr);
            check($sformatf("tbl%0d_z", i), 32'(z), 32'(tbl[i].ez));
            check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].ec));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
        end

        // Gaps: en=0 bubbles must not move pulse positions in valid-bit terms.
        do_reset();
        pos.delete();
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            send(((i % 2) == 0) ? 1'b1 : 1'b0);
            vcount++;
            if (z) pos.push_back(vcount);
            if (i < 9) begin
                int g;
                g = $urandom_range(1, 3);
                for (int j = 0; j < g; j++) begin
                    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
                    if (z) pos.push_back(-1);
                end
            end
        end
        npos = pos.size();
        check("gap_pulses", 32'(npos), 32'd3);
        if (npos == 3) begin
            check("gap_pos0", 32'(pos[0]), 32'd6);
            check("gap_pos1", 32'(pos[1]), 32'd8);
            check("gap_pos2", 32'(pos[2]), 32'd10);
        end
        check("gap_cnt", 32'(cnt), 32'd3);

        // Reset mid-stream discards history.
        do_reset();
        send(1); send(0); send(1); send(0); send(1);
        do_reset();
        send(0);
        check("post_reset_z", 32'(z), 32'd0);

        // cfg_load on the completing edge wins and drops that bit.
        do_reset();
        send(1); send(0); send(1); send(0); send(1);
        step(1'b1, 1'b0, 1'b1, 8'h2A, 4'd6, 1'b1, 1'b0);
        check("load_prio_z", 32'(z), 32'd0);
        send(1); send(0); send(1); send(0); send(1);
        check("load_prio_5th", 32'(z), 32'd0);
        send(0);
        check("load_prio_6th", 32'(z), 32'd1);

        // Saturation of the 2-bit counter and clear-on-match.
        do_reset();
        for (int i = 0; i < 12; i++) send(((i % 2) == 0) ? 1'b1 : 1'b0);
        check("sat_cnt", 32'(cnt_s), 32'd3);
        check("wide_cnt", 32'(cnt), 32'd4);
        send(1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        check("clr_match_z", 32'(z), 32'd1);
        check("clr_match_cnt", 32'(cnt), 32'd1);
        check("clr_match_cnt_sat", 32'(cnt_s), 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
            end else if (r < 40) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                     8'($urandom_range(0, 255)), 4'($urandom_range(0, 10)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
            end else begin
                step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                     8'h00, 4'd0, 1'b0, 1'($urandom_range(0, 49) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial bit-pattern detector. Generalises the fixed 101010 detector to any pattern of 1..MAX_LEN bits.
- Adds selectable overlapping or non-overlapping detection, an input-valid qualifier, a saturating match counter and a configuration error flag.
- Sits on a 1-bit serial input stream. Drives a single-cycle match pulse to downstream control logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2). LW = clog2(MAX_LEN+1).
- CNT_W, 8: width of the match counter.
- RST_PAT, 8'b0010_1010: pattern after reset, right-aligned (low RST_LEN bits used).
- RST_LEN, 6: pattern length after reset.
- RST_OVL, 1: overlap mode after reset (1 = overlapping).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  x valid this cycle
- x  in  1  serial data bit
- cfg_load  in  1  load pat_in/len_in/ovl_in this cycle
- pat_in  in  MAX_LEN  new pattern, right-aligned
- len_in  in  LW  new pattern length
- ovl_in  in  1  new overlap mode
- cnt_clr  in  1  synchronous clear of match_cnt
- z  out  1  match pulse, registered
- match_cnt  out  CNT_W  saturating count of matches
- cfg_err  out  1  sticky flag: last cfg_load rejected

Behaviour:
- Reset (async, rst=1): z=0, match_cnt=0, cfg_err=0. History and fill count cleared. Config takes RST_PAT/RST_LEN/RST_OVL.
- Bit order: first-received bit of a match compares to pat[len-1]; last-received bit compares to pat[0].
- State: history shift register hist[MAX_LEN-1:0], fill counter fill (0..len, saturating at len), active config pat/len/ovl.
- On a clock edge with en=1 and cfg_load=0:
  - hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, len).
  - A match exists if the new fill equals len and the new hist[len-1:0] equals pat[len-1:0].
- On match:
  - z=1 for exactly the one cycle after that edge.
  - match_cnt increments, saturating at all-ones.
  - ovl=1: fill keeps its value, so the next match may share bits.
  - ovl=0: fill <= 0, so the next match needs len fresh bits.
- z=0 on every other edge, including any edge where en=0.
- en=0: hist, fill and match_cnt hold (except cnt_clr). x is ignored.
- cfg_load=1, valid case (1 <= len_in <= MAX_LEN):
  - pat/len/ovl are updated, hist and fill are cleared, cfg_err <= 0, z <= 0.
  - The x bit on that edge is discarded even if en=1; cfg_load has priority.
- cfg_load=1, invalid case (len_in=0 or len_in>MAX_LEN):
  - Config, hist and fill are unchanged, cfg_err <= 1, z <= 0, and the x bit is discarded.
- Pattern bits above len-1 are don't-care and are never compared.
- cnt_clr=1: match_cnt <= 0. If a match occurs on the same edge, match_cnt <= 1 and z still pulses.
- len=1: every valid bit equal to pat[0] matches. This holds in both overlap modes, and back-to-back z pulses are allowed.
- Reset mid-stream discards all partial history. A match needs len valid bits received after reset is released.
- Latency: z rises on the edge that samples the final pattern bit and is visible for one cycle. There is no combinational path from x to z.

Test Plan:
- Reset defaults, overlap: en=1, x stream 1,0,1,0,1,0,1,0,1,0 -> z pulses after bits 6, 8 and 10; match_cnt=3; cfg_err=0.
- Non-overlap: cfg_load with pat=6'b101010, len=6, ovl=0, then the same 10-bit stream -> one z pulse after bit 6; match_cnt=1.
- Reprogram: cfg_load with pat=3'b110, len=3, ovl=0; stream 1,1,0,1,1,0,1,0 -> z after bits 3 and 6; match_cnt=2. Same stream with ovl=1 -> same 2 pulses (no overlap possible for 110).
- Gaps and invalid load: repeat the overlap stream with en=0 for 1-3 random cycles between bits -> identical pulse positions counted in valid bits. Then cfg_load with len_in=0 -> cfg_err=1, and the old config still detects.
- Reset and priority: drive bits 1,0,1,0,1, pulse rst, then bit 0 -> no z. Next, assert cfg_load on the edge that would complete a match -> no z, and that bit is dropped.
- Saturation: CNT_W=2, overlap, 12-bit stream of 101010... -> 4 matches occur and match_cnt stays at 3. cnt_clr on a match edge -> match_cnt=1.
